// File: rtl/branch_pc_ctrl_if.sv
// rtl/branch_pc_ctrl_if.sv - fetch/decode/execute branch bus for branch_pc_ctrl
interface branch_pc_ctrl_if;
  logic        stall;
  logic [31:0] pc;
  logic        dec_valid;
  logic [31:0] dec_pc;
  logic [31:0] dec_target;
  logic        dec_pred_taken;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_taken;
  logic        ex_pred;
  logic        flush_id;
  logic        flush_ex;

  modport master (
    output stall, dec_valid, dec_pc, dec_target,
    output ex_valid, ex_pc, ex_target, ex_taken, ex_pred,
    input  pc, dec_pred_taken, flush_id, flush_ex
  );

  modport slave (
    input  stall, dec_valid, dec_pc, dec_target,
    input  ex_valid, ex_pc, ex_target, ex_taken, ex_pred,
    output pc, dec_pred_taken, flush_id, flush_ex
  );
endinterface

// File: rtl/branch_pc_ctrl.sv
// rtl/branch_pc_ctrl.sv - fetch PC sequencer with bimodal predictor; BP_STATS_EN adds counters
module branch_pc_ctrl #(
  parameter int          IDX_BITS = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  branch_pc_ctrl_if.slave     bus
`ifdef BP_STATS_EN
  ,
  output logic [31:0]         stat_branches,
  output logic [31:0]         stat_mispredicts
`endif
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [31:0]         pc_q;
  logic [31:0]         pc_next;
  logic [31:0]         correct_pc;
  logic [1:0]          table_q [ENTRIES];
  logic [IDX_BITS-1:0] dec_idx;
  logic [IDX_BITS-1:0] ex_idx;
  logic [1:0]          ex_ctr;
  logic [1:0]          ex_ctr_next;
  logic                mispredict;
  logic                dec_redirect;
  logic                pred_bit;

  assign dec_idx = bus.dec_pc[IDX_BITS+1:2];
  assign ex_idx  = bus.ex_pc[IDX_BITS+1:2];

  // Only the index bits of the branch PCs address the table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.dec_pc[31:IDX_BITS+2], bus.dec_pc[1:0],
                            bus.ex_pc[1:0]};

  assign pred_bit           = table_q[dec_idx][1];
  assign bus.dec_pred_taken = bus.dec_valid & pred_bit;

  assign mispredict   = !rst && bus.ex_valid && (bus.ex_taken != bus.ex_pred);
  assign dec_redirect = !rst && bus.dec_pred_taken && !bus.stall && !mispredict;
  assign correct_pc   = bus.ex_taken ? bus.ex_target : bus.ex_pc + 32'd4;

  assign bus.flush_ex = mispredict;
  assign bus.flush_id = mispredict | dec_redirect;
  assign bus.pc       = pc_q;

  always_comb begin
    pc_next = pc_q + 32'd4;
    if (mispredict) begin
      pc_next = correct_pc;
    end else if (dec_redirect) begin
      pc_next = bus.dec_target;
    end else if (bus.stall) begin
      pc_next = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_next;
    end
  end

  // Saturating 2-bit counter step toward the resolved outcome.
  assign ex_ctr = table_q[ex_idx];
  always_comb begin
    ex_ctr_next = ex_ctr;
    if (bus.ex_taken) begin
      if (ex_ctr != 2'b11) ex_ctr_next = ex_ctr + 2'd1;
    end else begin
      if (ex_ctr != 2'b00) ex_ctr_next = ex_ctr - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= 2'b01;
      end
    end else if (bus.ex_valid) begin
      table_q[ex_idx] <= ex_ctr_next;
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= 32'd0;
      stat_mispredicts <= 32'd0;
    end else begin
      if (bus.ex_valid) stat_branches <= stat_branches + 32'd1;
      if (mispredict)   stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_pc_ctrl.sv
// tb/tb_branch_pc_ctrl.sv - directed self-checking bench for branch_pc_ctrl
module tb_branch_pc_ctrl;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  branch_pc_ctrl_if bus ();

`ifdef BP_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  branch_pc_ctrl #(
    .IDX_BITS(6),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef BP_STATS_EN
    ,
    .stat_branches(stat_branches),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [31:0] p, input logic [31:0] t,
                        input logic tk, input logic pr);
    bus.ex_valid  = v;
    bus.ex_pc     = p;
    bus.ex_target = t;
    bus.ex_taken  = tk;
    bus.ex_pred   = pr;
  endtask

  task automatic set_dec(input logic v, input logic [31:0] p, input logic [31:0] t);
    bus.dec_valid  = v;
    bus.dec_pc     = p;
    bus.dec_target = t;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.stall = 1'b0;
    set_dec(1'b0, 32'h0, 32'h0);
    set_ex(1'b1, 32'h40, 32'h900, 1'b1, 1'b0);
    settle();
    chk("rst_flush_ex", {31'd0, bus.flush_ex}, 32'd0);
    chk("rst_flush_id", {31'd0, bus.flush_id}, 32'd0);
    step();
    chk("reset_pc", bus.pc, 32'h0);

    rst = 1'b0;
    set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    settle();
    chk("idle_flush_ex", {31'd0, bus.flush_ex}, 32'd0);
    chk("idle_flush_id", {31'd0, bus.flush_id}, 32'd0);
    step();
    chk("idle_pc4", bus.pc, 32'h4);
    step();
    chk("idle_pc8", bus.pc, 32'h8);
    step();
    chk("idle_pc12", bus.pc, 32'hC);

    // Train 0x40 taken twice; the first cycle also reads the same entry.
    set_dec(1'b1, 32'h40, 32'h80);
    set_ex(1'b1, 32'h40, 32'h80, 1'b1, 1'b1);
    settle();
    chk("same_cycle_old", {31'd0, bus.dec_pred_taken}, 32'd0);
    step();
    chk("train_pc16", bus.pc, 32'h10);
    set_dec(1'b0, 32'h40, 32'h80);
    step();
    chk("train_pc20", bus.pc, 32'h14);
    set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    set_dec(1'b1, 32'h40, 32'h80);
    settle();
    chk("dec_taken_pred", {31'd0, bus.dec_pred_taken}, 32'd1);
    chk("dec_taken_flush_id", {31'd0, bus.flush_id}, 32'd1);
    chk("dec_taken_flush_ex", {31'd0, bus.flush_ex}, 32'd0);
    step();
    chk("dec_redirect_pc", bus.pc, 32'h80);
    set_dec(1'b0, 32'h0, 32'h0);

    // Not-taken mispredict overrides stall.
    bus.stall = 1'b1;
    set_ex(1'b1, 32'h100, 32'h500, 1'b0, 1'b1);
    settle();
    chk("misp_flush_ex", {31'd0, bus.flush_ex}, 32'd1);
    chk("misp_flush_id", {31'd0, bus.flush_id}, 32'd1);
    step();
    chk("misp_pc", bus.pc, 32'h104);
    set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    chk("stall_hold", bus.pc, 32'h104);

    set_dec(1'b1, 32'h40, 32'h80);
    settle();
    chk("stall_dec_pred", {31'd0, bus.dec_pred_taken}, 32'd1);
    chk("stall_dec_flush_id", {31'd0, bus.flush_id}, 32'd0);
    step();
    chk("stall_dec_pc", bus.pc, 32'h104);

    // Mispredict and decode redirect together: mispredict wins.
    bus.stall = 1'b0;
    set_dec(1'b1, 32'h40, 32'h300);
    set_ex(1'b1, 32'h1FC, 32'h200, 1'b1, 1'b0);
    settle();
    chk("both_flush_ex", {31'd0, bus.flush_ex}, 32'd1);
    chk("both_flush_id", {31'd0, bus.flush_id}, 32'd1);
    step();
    chk("both_pc", bus.pc, 32'h200);
    set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    bus.stall = 1'b1;
    set_dec(1'b1, 32'h1FC, 32'h0);
    settle();
    chk("trained_1fc", {31'd0, bus.dec_pred_taken}, 32'd1);

    // Entry 0x40 is 11; walk it down and check saturation at both ends.
    set_dec(1'b1, 32'h40, 32'h80);
    set_ex(1'b1, 32'h40, 32'h0, 1'b0, 1'b0);
    step();
    set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    settle();
    chk("dec_after_nt1", {31'd0, bus.dec_pred_taken}, 32'd1);
    set_ex(1'b1, 32'h40, 32'h0, 1'b0, 1'b0);
    step();
    set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    settle();
    chk("dec_after_nt2", {31'd0, bus.dec_pred_taken}, 32'd0);
    set_ex(1'b1, 32'h40, 32'h0, 1'b0, 1'b0);
    step();
    step();
    step();
    set_ex(1'b1, 32'h40, 32'h80, 1'b1, 1'b1);
    step();
    settle();
    chk("sat_low_a", {31'd0, bus.dec_pred_taken}, 32'd0);
    step();
    set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    settle();
    chk("sat_low_b", {31'd0, bus.dec_pred_taken}, 32'd1);
    set_ex(1'b1, 32'h40, 32'h80, 1'b1, 1'b1);
    step();
    step();
    step();
    set_ex(1'b1, 32'h40, 32'h0, 1'b0, 1'b0);
    step();
    set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    settle();
    chk("sat_high", {31'd0, bus.dec_pred_taken}, 32'd1);
    chk("stall_hold_long", bus.pc, 32'h200);

    // PC wrap through both adders.
    bus.stall = 1'b0;
    set_dec(1'b0, 32'h0, 32'h0);
    set_ex(1'b1, 32'h10, 32'hFFFF_FFFC, 1'b1, 1'b0);
    step();
    chk("pc_top", bus.pc, 32'hFFFF_FFFC);
    set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    chk("pc_wrap", bus.pc, 32'h0);
    set_ex(1'b1, 32'hFFFF_FFFC, 32'h700, 1'b0, 1'b1);
    step();
    chk("ex_pc_wrap", bus.pc, 32'h0);
    set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    chk("pc_after_wrap", bus.pc, 32'h4);

    // Reset during pending redirects.
    set_dec(1'b1, 32'h40, 32'h80);
    set_ex(1'b1, 32'h20, 32'h600, 1'b1, 1'b0);
    rst = 1'b1;
    settle();
    chk("rst_mid_flush_id", {31'd0, bus.flush_id}, 32'd0);
    chk("rst_mid_flush_ex", {31'd0, bus.flush_ex}, 32'd0);
    step();
    chk("rst_mid_pc", bus.pc, 32'h0);
    rst = 1'b0;
    bus.stall = 1'b1;
    set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    settle();
    chk("table_reset_40", {31'd0, bus.dec_pred_taken}, 32'd0);
    set_dec(1'b1, 32'h1FC, 32'h80);
    settle();
    chk("table_reset_1fc", {31'd0, bus.dec_pred_taken}, 32'd0);

`ifdef BP_STATS_EN
    chk("stats_br_reset", stat_branches, 32'd0);
    chk("stats_mp_reset", stat_mispredicts, 32'd0);
    set_dec(1'b0, 32'h0, 32'h0);
    set_ex(1'b1, 32'h8, 32'h80, 1'b1, 1'b1);
    step();
    set_ex(1'b1, 32'h8, 32'h80, 1'b0, 1'b1);
    step();
    set_ex(1'b1, 32'h8, 32'h80, 1'b0, 1'b0);
    step();
    set_ex(1'b1, 32'h8, 32'h80, 1'b1, 1'b0);
    step();
    set_ex(1'b1, 32'h8, 32'h80, 1'b1, 1'b1);
    step();
    set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    settle();
    chk("stats_branches", stat_branches, 32'd5);
    chk("stats_mispredicts", stat_mispredicts, 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("stats_br_rst", stat_branches, 32'd0);
    chk("stats_mp_rst", stat_mispredicts, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_pc_ctrl.md
# branch_pc_ctrl

Fetch-PC sequencer and bimodal branch predictor for the 5-stage core. It owns the fetch PC register and a table of 2-bit saturating counters. In decode it predicts conditional branches and redirects fetch to the decoded target when predicting taken. It takes the resolved outcome from the execute-stage branch comparator, repairs mispredictions with a redirect and flush, and trains the counter table.

## Interface
- `IDX_BITS`, 6: predictor index width; table has 2^IDX_BITS entries, indexed by PC[IDX_BITS+1:2].
- `RESET_PC`, 32'h0000_0000: fetch PC after reset.

- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  reset; synchronous, active-high.
- `stall`  in  1  pipeline hazard stall; hold PC.
- `pc`  out  32  current fetch PC, registered.
- `dec_valid`  in  1  decode holds a valid conditional branch.
- `dec_pc`  in  32  PC of the decode-stage branch.
- `dec_target`  in  32  decoded branch target (PC + B-immediate).
- `dec_pred_taken`  out  1  prediction for dec_pc; carried down the pipe to `ex_pred`.
- `ex_valid`  in  1  execute-stage branch resolving this cycle.
- `ex_pc`  in  32  PC of the resolving branch.
- `ex_target`  in  32  branch target.
- `ex_taken`  in  1  actual outcome (comparator take_branch).
- `ex_pred`  in  1  prediction made for this branch in decode.
- `flush_id`  out  1  kill the instruction in IF/ID.
- `flush_ex`  out  1  kill the instructions in IF/ID and ID/EX.

## Operation
- Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Predict taken when bit[1] = 1.
- `dec_pred_taken` = dec_valid & table[dec_pc idx][1]. It is a combinational read.
- Mispredict: ex_valid & (ex_taken != ex_pred).
  - Correct PC = ex_taken ? ex_target : ex_pc + 4. The add wraps mod 2^32.
- Decode redirect: dec_pred_taken & !stall & !mispredict.
- Next-PC priority:
  1. rst → RESET_PC
  2. mispredict → correct PC
  3. decode redirect → dec_target
  4. stall → hold
  5. otherwise pc + 4, wrapping mod 2^32
- Mispredict overrides stall.
- A decode redirect is dropped during a stall. The held decode instruction re-predicts next cycle.
- `flush_ex` = mispredict.
- `flush_id` = mispredict | decode redirect.
- Training on every ex_valid, at the ex_pc index:
  - taken: saturating increment.
  - not taken: saturating decrement.
  - 11 +1 stays 11; 00 −1 stays 00.
  - Training happens regardless of stall or flush.
- Same-cycle read/write of one index: the decode read returns the old counter value. The update is visible the following cycle.
- No misalignment check. PC[1:0] are carried as given.

## Timing
- Reset, on the edge where rst = 1:
  - pc = RESET_PC.
  - Every table entry = 01.
  - Stats counters = 0.
- While rst = 1: flush_id = flush_ex = 0, and all training and redirects are suppressed.
- Latency:
  - dec_pred_taken, flush_id and flush_ex are combinational, valid in the cause cycle.
  - pc takes the redirect target at the next rising edge (one cycle).
  - Counter updates commit at the edge ending the ex_valid cycle.
- Mispredict penalty: 2 cycles. Decode-taken penalty: 1 cycle.
- Reset asserted mid-redirect: reset wins, and the pending redirect is lost.

## Configuration
- `BP_STATS_EN` defined: adds two outputs, each a 32-bit wrapping counter.
  - `stat_branches`: increments on every ex_valid.
  - `stat_mispredicts`: increments on every mispredict.
  - Both reset to 0.
- `BP_STATS_EN` undefined: neither port nor counter exists. All other behaviour is identical.

## Test plan
- Reset, then 3 idle cycles → pc = 0, 4, 8, 12; flushes low; dec_pred_taken = 0 for any valid branch (entries 01).
- Train: ex_valid, ex_pc = 0x40, taken, 2 cycles → entry[16] = 11. Then dec_valid, dec_pc = 0x40, dec_target = 0x80 → dec_pred_taken = 1, flush_id = 1, pc = 0x80 next cycle.
- Mispredict not-taken: ex_pc = 0x100, ex_pred = 1, ex_taken = 0, stall = 1 → flush_ex = flush_id = 1, pc = 0x104 next cycle despite stall.
- Simultaneous events: mispredict to 0x200 plus decode predicted-taken to 0x300 in the same cycle → pc = 0x200; decode redirect suppressed. Separately, a decode-taken prediction with stall = 1 → pc holds, flush_id = 0.
- Saturation and wrap:
  - Four not-taken resolves at an index → counter 00; a fifth keeps 00.
  - pc = 0xFFFF_FFFC, no redirect → next pc = 0.
  - Same-cycle read/update → old value read.
- With BP_STATS_EN: 5 resolves, 2 mispredicts → stat_branches = 5, stat_mispredicts = 2; rst → both 0.
